// File: rtl/bfs_level_ctrl_if.sv
// Root-injection handshake between the BFS level controller and the frontier queue.
interface bfs_level_ctrl_if #(
    parameter int unsigned VID_W = 32
);
    logic             root_valid;
    logic             root_ready;
    logic [VID_W-1:0] root_data;

    // Controller side: offers the root vertex.
    modport master (
        output root_valid,
        output root_data,
        input  root_ready
    );

    // Frontier-queue side: accepts the root vertex.
    modport slave (
        input  root_valid,
        input  root_data,
        output root_ready
    );
endinterface

// File: rtl/bfs_level_ctrl.sv
// BFS level-synchronous traversal controller: injects the root, opens each level,
// gathers per-PE completion and new-vertex counts, and decides when traversal ends.
module bfs_level_ctrl #(
    parameter int unsigned NUM_PE = 4,
    parameter int unsigned VID_W  = 32,
    parameter int unsigned LVL_W  = 16
) (
    input  logic              gt_txusrclk,
    input  logic              peripheral_aresetn,
    input  logic              start,
    input  logic [VID_W-1:0]  root_vid,
    input  logic [LVL_W-1:0]  max_level,
    bfs_level_ctrl_if.master  root,
    output logic              level_start,
    input  logic [NUM_PE-1:0] pe_done,
    input  logic [NUM_PE-1:0] upd_fire,
    output logic [1:0]        status,
    output logic [LVL_W-1:0]  level,
    output logic [VID_W-1:0]  visited_cnt,
    output logic              err
);

    localparam int unsigned PcW = $clog2(NUM_PE + 1);

    typedef enum logic [2:0] {
        StIdle,
        StInject,
        StScatter,
        StSync,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [VID_W-1:0]  root_q, root_d;
    logic [LVL_W-1:0]  max_q, max_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [VID_W-1:0]  vis_q, vis_d;
    logic [VID_W-1:0]  next_q, next_d;
    logic [NUM_PE-1:0] done_q, done_d;
    logic              first_q, first_d;
    logic              err_q, err_d;
    logic [LVL_W-1:0]  level_inc;

    function automatic logic [PcW-1:0] popcount(input logic [NUM_PE-1:0] v);
        logic [PcW-1:0] c;
        c = '0;
        for (int i = 0; i < int'(NUM_PE); i++) begin
            c = c + PcW'(v[i]);
        end
        return c;
    endfunction

    // Counts stick at all-ones rather than wrapping.
    function automatic logic [VID_W-1:0] sat_add(input logic [VID_W-1:0] a,
                                                 input logic [VID_W-1:0] b);
        logic [VID_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[VID_W] ? '1 : s[VID_W-1:0];
    endfunction

    assign level_inc = level_q + LVL_W'(1);

    // Next-state logic: traversal sequencing, counting and error tracking.
    always_comb begin
        state_d = state_q;
        root_d  = root_q;
        max_d   = max_q;
        level_d = level_q;
        vis_d   = vis_q;
        next_d  = next_q;
        done_d  = done_q;
        first_d = 1'b0;
        err_d   = err_q;

        // Update pulses are only meaningful while PEs are scattering.
        if (state_q != StScatter && (|upd_fire)) begin
            err_d = 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (start) begin
                    root_d  = root_vid;
                    max_d   = max_level;
                    state_d = StInject;
                end
            end
            StInject: begin
                if (root.root_ready) begin
                    level_d = '0;
                    vis_d   = VID_W'(1);
                    next_d  = '0;
                    first_d = 1'b1;
                    state_d = StScatter;
                end
            end
            StScatter: begin
                next_d = sat_add(next_q, VID_W'(popcount(upd_fire)));
                if (first_q) begin
                    // Opening cycle: forget the previous level's completions.
                    done_d = '0;
                end else begin
                    done_d = done_q | pe_done;
                    if (&(done_q | pe_done)) begin
                        state_d = StSync;
                    end
                end
            end
            StSync: begin
                vis_d = sat_add(vis_q, next_q);
                if (next_q == '0 || (max_q != '0 && level_inc == max_q)) begin
                    state_d = StDone;
                end else begin
                    level_d = level_inc;
                    next_d  = '0;
                    first_d = 1'b1;
                    state_d = StScatter;
                end
            end
            StDone: begin
                if (start) begin
                    // A stray pulse in the restart cycle still counts as an error.
                    err_d   = |upd_fire;
                    root_d  = root_vid;
                    max_d   = max_level;
                    state_d = StInject;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge gt_txusrclk or negedge peripheral_aresetn) begin
        if (!peripheral_aresetn) begin
            state_q <= StIdle;
            root_q  <= '0;
            max_q   <= '0;
            level_q <= '0;
            vis_q   <= '0;
            next_q  <= '0;
            done_q  <= '0;
            first_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            root_q  <= root_d;
            max_q   <= max_d;
            level_q <= level_d;
            vis_q   <= vis_d;
            next_q  <= next_d;
            done_q  <= done_d;
            first_q <= first_d;
            err_q   <= err_d;
        end
    end

    // Outputs decoded from registered state only.
    always_comb begin
        unique case (state_q)
            StIdle:    status = 2'd0;
            StInject:  status = 2'd1;
            StScatter: status = 2'd1;
            StSync:    status = 2'd2;
            StDone:    status = 2'd3;
            default:   status = 2'd0;
        endcase
    end

    assign root.root_valid = (state_q == StInject);
    assign root.root_data  = root_q;
    assign level_start     = (state_q == StScatter) && first_q;
    assign level           = level_q;
    assign visited_cnt     = vis_q;
    assign err             = err_q;

endmodule

// File: tb/tb_bfs_level_ctrl.sv
// Directed bench for bfs_level_ctrl: a cycle table for the main traversals plus
// hand-written sequences for backpressure, stray updates and mid-traversal reset.
module tb_bfs_level_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] root_vid;
    logic [15:0] max_level;
    logic        level_start;
    logic [3:0]  pe_done;
    logic [3:0]  upd_fire;
    logic [1:0]  status;
    logic [15:0] level;
    logic [31:0] visited_cnt;
    logic        err;

    int n_vec = 0;
    int n_bad = 0;

    bfs_level_ctrl_if #(.VID_W(32)) rif ();

    bfs_level_ctrl #(
        .NUM_PE(4),
        .VID_W (32),
        .LVL_W (16)
    ) dut (
        .gt_txusrclk       (clk),
        .peripheral_aresetn(rst_n),
        .start             (start),
        .root_vid          (root_vid),
        .max_level         (max_level),
        .root              (rif),
        .level_start       (level_start),
        .pe_done           (pe_done),
        .upd_fire          (upd_fire),
        .status            (status),
        .level             (level),
        .visited_cnt       (visited_cnt),
        .err               (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic [31:0] rvid;
        logic [15:0] maxl;
        logic        rready;
        logic [3:0]  done;
        logic [3:0]  upd;
        logic [1:0]  e_status;
        logic        e_rv;
        logic [31:0] e_rdata;
        logic        e_ls;
        logic [15:0] e_lvl;
        logic [31:0] e_vis;
        logic        e_err;
    } vec_t;

    vec_t tv[22];

    function automatic vec_t mk(bit s, int rv, int ml, bit rr, int d, int u,
                                int es, bit erv, int erd, bit els, int elv, int evis, bit eerr);
        vec_t v;
        v.start    = s;
        v.rvid     = 32'(rv);
        v.maxl     = 16'(ml);
        v.rready   = rr;
        v.done     = 4'(d);
        v.upd      = 4'(u);
        v.e_status = 2'(es);
        v.e_rv     = erv;
        v.e_rdata  = 32'(erd);
        v.e_ls     = els;
        v.e_lvl    = 16'(elv);
        v.e_vis    = 32'(evis);
        v.e_err    = eerr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Drive one cycle's inputs on the falling edge, then let outputs settle.
    task automatic cyc(input logic s, input logic [31:0] rv, input logic [15:0] ml,
                       input logic rr, input logic [3:0] d, input logic [3:0] u);
        @(negedge clk);
        start          = s;
        root_vid       = rv;
        max_level      = ml;
        rif.root_ready = rr;
        pe_done        = d;
        upd_fire       = u;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Cycle table:    st rvid ml rr done upd | status rv rdata ls lvl vis err
        tv[0]  = mk(1, 5, 0, 1, 'h0, 'h0, 0, 0, 0, 0, 0, 0,  0);
        tv[1]  = mk(0, 5, 0, 1, 'h0, 'h0, 1, 1, 5, 0, 0, 0,  0);
        tv[2]  = mk(0, 5, 0, 1, 'hF, 'h3, 1, 0, 5, 1, 0, 1,  0);
        tv[3]  = mk(0, 5, 0, 1, 'h0, 'h1, 1, 0, 5, 0, 0, 1,  0);
        tv[4]  = mk(0, 5, 0, 1, 'hF, 'h0, 1, 0, 5, 0, 0, 1,  0);
        tv[5]  = mk(0, 5, 0, 1, 'h0, 'h0, 2, 0, 5, 0, 0, 1,  0);
        tv[6]  = mk(0, 5, 0, 1, 'h0, 'hF, 1, 0, 5, 1, 1, 4,  0);
        tv[7]  = mk(0, 5, 0, 1, 'h3, 'h1, 1, 0, 5, 0, 1, 4,  0);
        tv[8]  = mk(0, 5, 0, 1, 'hC, 'h5, 1, 0, 5, 0, 1, 4,  0);
        tv[9]  = mk(0, 5, 0, 1, 'h0, 'h0, 2, 0, 5, 0, 1, 4,  0);
        tv[10] = mk(0, 5, 0, 1, 'hF, 'h0, 1, 0, 5, 1, 2, 11, 0);
        tv[11] = mk(0, 5, 0, 1, 'hF, 'h0, 1, 0, 5, 0, 2, 11, 0);
        tv[12] = mk(0, 5, 0, 1, 'h0, 'h0, 2, 0, 5, 0, 2, 11, 0);
        tv[13] = mk(1, 9, 2, 1, 'h0, 'h0, 3, 0, 5, 0, 2, 11, 0);
        tv[14] = mk(0, 9, 2, 1, 'h0, 'h0, 1, 1, 9, 0, 2, 11, 0);
        tv[15] = mk(0, 9, 2, 1, 'h0, 'hF, 1, 0, 9, 1, 0, 1,  0);
        tv[16] = mk(0, 9, 2, 1, 'hF, 'h0, 1, 0, 9, 0, 0, 1,  0);
        tv[17] = mk(0, 9, 2, 1, 'h0, 'h0, 2, 0, 9, 0, 0, 1,  0);
        tv[18] = mk(0, 9, 2, 1, 'h0, 'hF, 1, 0, 9, 1, 1, 5,  0);
        tv[19] = mk(0, 9, 2, 1, 'hF, 'h0, 1, 0, 9, 0, 1, 5,  0);
        tv[20] = mk(0, 9, 2, 1, 'h0, 'h0, 2, 0, 9, 0, 1, 5,  0);
        tv[21] = mk(0, 9, 2, 1, 'h0, 'h0, 3, 0, 9, 0, 1, 9,  0);

        start          = 1'b0;
        root_vid       = '0;
        max_level      = '0;
        rif.root_ready = 1'b0;
        pe_done        = '0;
        upd_fire       = '0;
        rst_n          = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 22; i++) begin
            cyc(tv[i].start, tv[i].rvid, tv[i].maxl, tv[i].rready, tv[i].done, tv[i].upd);
            chk($sformatf("v%0d status", i), 32'(status), 32'(tv[i].e_status));
            chk($sformatf("v%0d root_valid", i), 32'(rif.root_valid), 32'(tv[i].e_rv));
            chk($sformatf("v%0d root_data", i), rif.root_data, tv[i].e_rdata);
            chk($sformatf("v%0d level_start", i), 32'(level_start), 32'(tv[i].e_ls));
            chk($sformatf("v%0d level", i), 32'(level), 32'(tv[i].e_lvl));
            chk($sformatf("v%0d visited_cnt", i), visited_cnt, tv[i].e_vis);
            chk($sformatf("v%0d err", i), 32'(err), 32'(tv[i].e_err));
        end

        // Restart from DONE with the queue back-pressuring the root for 5 cycles.
        cyc(1, 7, 0, 0, 'h0, 'h0);
        chk("bp done status", 32'(status), 32'd3);
        for (int k = 0; k < 5; k++) begin
            cyc(0, 7, 0, 0, 'h0, 'h0);
            chk($sformatf("bp%0d root_valid", k), 32'(rif.root_valid), 32'd1);
            chk($sformatf("bp%0d root_data", k), rif.root_data, 32'd7);
            chk($sformatf("bp%0d level_start", k), 32'(level_start), 32'd0);
            chk($sformatf("bp%0d status", k), 32'(status), 32'd1);
        end
        cyc(0, 7, 0, 1, 'h0, 'h0);
        chk("bp accept root_valid", 32'(rif.root_valid), 32'd1);
        cyc(0, 7, 0, 0, 'h0, 'h4);
        chk("bp first level_start", 32'(level_start), 32'd1);
        chk("bp first visited", visited_cnt, 32'd1);
        cyc(0, 7, 0, 0, 'hF, 'h0);
        chk("bp scatter no pulse", 32'(level_start), 32'd0);

        // Stray updates during SYNC raise err and are not counted.
        cyc(0, 7, 0, 0, 'h0, 'hF);
        chk("sync status", 32'(status), 32'd2);
        chk("sync err before", 32'(err), 32'd0);
        cyc(0, 7, 0, 0, 'h0, 'h0);
        chk("after sync err", 32'(err), 32'd1);
        chk("after sync visited", visited_cnt, 32'd2);
        chk("after sync level", 32'(level), 32'd1);
        chk("after sync level_start", 32'(level_start), 32'd1);
        cyc(0, 7, 0, 0, 'hF, 'h0);
        cyc(0, 7, 0, 0, 'h0, 'h0);
        chk("empty level sync", 32'(status), 32'd2);
        cyc(0, 7, 0, 0, 'h0, 'hF);
        chk("done hold status", 32'(status), 32'd3);
        chk("done hold visited", visited_cnt, 32'd2);
        chk("done hold err", 32'(err), 32'd1);

        // Start in DONE clears err.
        cyc(1, 3, 0, 1, 'h0, 'h0);
        chk("restart err still", 32'(err), 32'd1);
        cyc(0, 3, 0, 1, 'h0, 'h0);
        chk("restart err clear", 32'(err), 32'd0);
        chk("restart root_data", rif.root_data, 32'd3);

        // Climb to level 3 with one new vertex per level.
        for (int lv = 0; lv < 3; lv++) begin
            cyc(0, 3, 0, 0, 'h0, 'h1);
            chk($sformatf("climb%0d level", lv), 32'(level), 32'(lv));
            cyc(0, 3, 0, 0, 'hF, 'h0);
            cyc(0, 3, 0, 0, 'h0, 'h0);
            chk($sformatf("climb%0d sync", lv), 32'(status), 32'd2);
        end
        cyc(0, 3, 0, 0, 'h0, 'h1);
        chk("lvl3 level", 32'(level), 32'd3);
        chk("lvl3 level_start", 32'(level_start), 32'd1);
        chk("lvl3 visited", visited_cnt, 32'd4);

        // Reset mid-SCATTER takes effect without a clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst status", 32'(status), 32'd0);
        chk("rst level", 32'(level), 32'd0);
        chk("rst visited", visited_cnt, 32'd0);
        chk("rst root_valid", 32'(rif.root_valid), 32'd0);
        chk("rst root_data", rif.root_data, 32'd0);
        chk("rst level_start", 32'(level_start), 32'd0);
        chk("rst err", 32'(err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc(0, 3, 0, 1, 'hF, 'h0);
            chk($sformatf("post-rst%0d level_start", k), 32'(level_start), 32'd0);
            chk($sformatf("post-rst%0d status", k), 32'(status), 32'd0);
        end

        // Update pulse while idle sets err.
        cyc(0, 3, 0, 1, 'h0, 'h1);
        cyc(0, 3, 0, 1, 'h0, 'h0);
        chk("idle err", 32'(err), 32'd1);
        chk("idle visited", visited_cnt, 32'd0);

        // A fresh start works after reset.
        cyc(1, 2, 0, 0, 'h0, 'h0);
        chk("fresh idle status", 32'(status), 32'd0);
        cyc(0, 2, 0, 1, 'h0, 'h0);
        chk("fresh root_valid", 32'(rif.root_valid), 32'd1);
        chk("fresh root_data", rif.root_data, 32'd2);
        cyc(0, 2, 0, 0, 'h0, 'h0);
        chk("fresh level_start", 32'(level_start), 32'd1);
        chk("fresh visited", visited_cnt, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/bfs_level_ctrl.md
BFS_LEVEL_CTRL -- requirements
Module: bfs_level_ctrl

Interface
REQ-001 SHALL have parameter NUM_PE, default 4, number of scatter/apply processing elements.
REQ-002 SHALL have parameter VID_W, default 32, vertex-ID and count width.
REQ-003 SHALL have parameter LVL_W, default 16, BFS level width.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port gt_txusrclk, input, 1, sole clock, all logic on the rising edge.
REQ-006 SHALL have port peripheral_aresetn, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port start, input, 1, one-cycle traversal start request.
REQ-008 SHALL have port root_vid, input, VID_W, root vertex, sampled when start is accepted.
REQ-009 SHALL have port max_level, input, LVL_W, level limit (0 = unlimited), sampled when start is accepted.
REQ-010 SHALL have port root_valid / root_ready / root_data, output/input/output, 1/1/VID_W, root-injection handshake to the frontier queue.
REQ-011 SHALL have port level_start, output, 1, one-cycle pulse opening a level.
REQ-012 SHALL have port pe_done, input, NUM_PE, per-PE level-complete pulse or level.
REQ-013 SHALL have port upd_fire, input, NUM_PE, per-PE one-cycle pulse for each newly visited vertex.
REQ-014 SHALL have port status, output, 2, 0 IDLE, 1 RUN, 2 SYNC, 3 DONE.
REQ-015 SHALL have ports level (LVL_W), visited_cnt (VID_W), err (1), all outputs.

Function
REQ-016 SHALL implement states IDLE, INJECT, SCATTER, SYNC, DONE; status = 0, 1, 1, 2, 3 respectively.
REQ-017 SHALL move IDLE->INJECT on start, latching root_vid and max_level; start in any other state except DONE SHALL be ignored.
REQ-018 SHALL in INJECT hold root_valid=1 with root_data stable until root_ready=1; that cycle sets level=0, visited_cnt=1, next_cnt=0, moves to SCATTER.
REQ-019 SHALL assert level_start for exactly the first cycle of each SCATTER entry and clear the done-latch vector in that cycle.
REQ-020 SHALL OR pe_done into a sticky NUM_PE-bit done-latch vector from the cycle after level_start; pe_done in the level_start cycle is ignored.
REQ-021 SHALL add popcount(upd_fire) to next_cnt every SCATTER cycle, including the level_start cycle and the cycle in which the final done bit arrives.
REQ-022 SHALL move SCATTER->SYNC in the cycle after the done-latch vector is all ones.
REQ-023 SHALL spend exactly one cycle in SYNC: if next_cnt==0, or max_level!=0 and level+1==max_level, go to DONE; else level<=level+1, visited_cnt<=visited_cnt+next_cnt, next_cnt<=0, go to SCATTER.
REQ-024 SHALL also add next_cnt to visited_cnt when terminating on max_level.
REQ-025 SHALL saturate visited_cnt and next_cnt at all-ones; no wrap.
REQ-026 SHALL set sticky err on any upd_fire bit in IDLE, INJECT, SYNC or DONE; those pulses are not counted.
REQ-027 SHALL hold level, visited_cnt, err in DONE; start in DONE clears err and restarts as from IDLE (goes to INJECT).

Reset
REQ-028 SHALL, on peripheral_aresetn low, immediately (no clock) force state IDLE, status 0, root_valid 0, root_data 0, level_start 0, level 0, visited_cnt 0, next_cnt 0, done latches 0, err 0.
REQ-029 SHALL, on reset asserted mid-traversal, abandon the traversal and produce no level_start pulse after release until a new start.
REQ-030 SHALL accept start no earlier than the first rising edge after reset release.

Verification
REQ-031 Basic: NUM_PE=4, root_vid=5, root_ready=1 -> root_valid one cycle with data 5, level_start next cycle, status 1.
REQ-032 Three levels: levels supply 3, 7, 0 upd_fire pulses then all pe_done -> level_start x3, final level=2, visited_cnt=11, status 3.
REQ-033 Limit: max_level=2, each level produces 4 updates -> DONE after two levels, level=1, visited_cnt=9.
REQ-034 Skew/simultaneous: pe_done bits on different cycles, 2 upd_fire bits set in the same cycle as the last done -> both counted, SYNC one cycle after last done.
REQ-035 Backpressure/error: root_ready low 5 cycles -> root_data stable, no level_start; upd_fire in SYNC -> err=1, count unchanged.
REQ-036 Reset mid-SCATTER at level 3 -> status 0, level 0, visited_cnt 0 immediately; no activity until next start.
